// File: rtl/regfile_writeback.sv
// Write-port arbiter for the x1..x15 register file: merges ALU results and in-order load returns,
// and tracks pending load destinations for hazard detection.
module regfile_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        issue_stall,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard1,
  output logic        hazard2,
  output logic [15:0] busy_mask,
  output logic [4:0]  A3,
  output logic        WE3,
  output logic [31:0] WD3
);

  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  logic [4:0]          queue_rd [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] slot_valid;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;

  logic        push;
  logic        pop;
  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign issue_stall = (count == CW'(LQ_DEPTH));
  assign ld_ready    = !alu_valid && (count != '0);
  assign push        = ld_issue && !issue_stall;
  assign pop         = ld_valid && ld_ready;

  // ALU always wins the write port; a load only writes when it actually transfers.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = queue_rd[head];
      sel_data  = ld_data;
    end
  end

  // Entries with rd 0 or rd > 15 occupy a slot for ordering but never mark a register busy.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (slot_valid[i] && !queue_rd[i][4]) begin
        busy_mask[queue_rd[i][3:0]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  assign hazard1 = !rs1[4] && busy_mask[rs1[3:0]];
  assign hazard2 = !rs2[4] && busy_mask[rs2[3:0]];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      slot_valid <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        queue_rd[i] <= '0;
      end
    end else begin
      if (push) begin
        queue_rd[tail]   <= ld_rd;
        slot_valid[tail] <= 1'b1;
        tail             <= (tail == PW'(LQ_DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        slot_valid[head] <= 1'b0;
        head             <= (head == PW'(LQ_DEPTH - 1)) ? '0 : head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A3/WD3 hold their last value when no write is selected.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      A3  <= '0;
      WE3 <= 1'b0;
      WD3 <= '0;
    end else begin
      WE3 <= sel_valid && (sel_rd != 5'd0) && !sel_rd[4];
      if (sel_valid) begin
        A3  <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the 15-entry integer register file (x1..x15, x0 hard-wired zero). Merges single-cycle ALU results and out-of-order-timed load returns into the register file's single write port (A3/WE3/WD3), one write per cycle, ALU first. Tracks in-flight load destinations in a small in-order queue and exposes a per-register busy mask and RAW hazard flags to issue logic.

## Interface
- LQ_DEPTH, 2, load-destination queue depth (≥1); count width is clog2(LQ_DEPTH+1)
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- alu_valid  in  1  ALU result present this cycle; always accepted (no ready)
- alu_rd  in  5  ALU destination
- alu_data  in  32  ALU result
- ld_issue  in  1  load issued this cycle; pushes ld_rd into queue
- ld_rd  in  5  destination of issued load
- issue_stall  out  1  queue full; ld_issue ignored while high
- ld_valid  in  1  load data returning
- ld_data  in  32  returned load data
- ld_ready  out  1  load return accepted this cycle (ld_valid && ld_ready = transfer)
- rs1, rs2  in  5 each  source registers of instruction in decode
- hazard1, hazard2  out  1 each  rsN is a pending load destination
- busy_mask  out  16  bit r set when xr has a pending load; bit 0 always 0
- A3  out  5  register-file write address
- WE3  out  1  register-file write enable
- WD3  out  32  register-file write data

## Operation
- Queue: FIFO of LQ_DEPTH 5-bit rd entries, head/tail pointers wrap modulo LQ_DEPTH, occupancy counter.
- Push: ld_issue && !issue_stall -> enqueue ld_rd (including rd 0 or >15, so ordering is kept).
- Pop: ld_valid && ld_ready -> dequeue head; head rd pairs with ld_data (returns are in issue order).
- issue_stall = (count == LQ_DEPTH), combinational. Push while full is dropped even if a pop occurs the same cycle.
- ld_ready = !alu_valid && (count != 0), combinational. Queue empty -> ld_ready 0; ld_valid then is held by LSU.
- Write select each cycle, priority order:
  - alu_valid -> write (alu_rd, alu_data).
  - else load transfer -> write (head rd, ld_data).
  - else no write.
- Registered outputs at posedge: WE3 = write selected && 1 ≤ rd ≤ 15; A3/WD3 = selected rd/data when a write is selected, otherwise held. rd 0 or rd >15 -> WE3 = 0, but a load still pops.
- busy_mask[r] = OR over valid queue entries of (entry == r), for r in 1..15; combinational from queue state. Two pending loads to the same rd keep the bit set until both pop.
- hazardN = busy_mask[rsN] when 1 ≤ rsN ≤ 15, else 0.
- alu_valid with alu_rd currently busy is a protocol violation (issue logic must stall on hazard); behaviour unspecified, not checked.

## Timing
- Reset values: A3 = 0, WE3 = 0, WD3 = 0, queue empty (count 0, pointers 0), busy_mask = 0, hazard1/2 = 0, issue_stall = 0, ld_ready = 0.
- Reset asserted mid-operation discards all pending loads; outputs at reset values within the same cycle (asynchronous).
- Latency: source valid in cycle N -> WE3/A3/WD3 valid for cycle N+1 only (one cycle high per write). The register file samples on the negedge inside cycle N+1.
- Busy update: push in cycle N -> busy bit set from cycle N+1; pop in N -> bit clears from N+1 (if no other entry matches). Decode must therefore also compare rsN against A3 when WE3 is high, since the write is not yet visible in the register file during cycle N+1.
- Simultaneous push and pop: both take effect; count unchanged; the popped entry leaves, the new entry appears.
- ALU and load return in the same cycle: ALU writes, ld_ready = 0, load retried next cycle.
- Back-to-back writes are sustained at one per cycle.

## Test plan
- Reset: assert reset mid-cycle with two loads pending -> A3 = 0, WE3 = 0, WD3 = 0, busy_mask = 0, issue_stall = 0 immediately.
- ALU write: alu_valid, rd = 5, data 0xDEADBEEF at cycle N -> cycle N+1 WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF; cycle N+2 WE3 = 0. rd = 0 -> WE3 stays 0.
- Load path: issue ld_rd = 7 -> busy_mask = 0x0080, hazard1 = 1 with rs1 = 7; ld_valid data 0x12345678 -> next cycle WE3 = 1, A3 = 7, busy_mask = 0.
- Conflict: alu_valid (rd 3, 0x1) and ld_valid (pending rd 9, 0x2) in the same cycle -> ld_ready = 0, write x3 = 0x1; next cycle ld_ready = 1, write x9 = 0x2.
- Full/wrap: issue rd 4, then rd 6 -> issue_stall = 1; third issue (rd 8) dropped; pop and issue 30 times with random rd -> WD3/A3 follow issue order, and pointer wrap is exercised.
- Duplicate rd: issue two loads to x10, return the first -> busy_mask[10] stays 1; return the second -> busy_mask[10] = 0.
